mlp_job_sequencer: RTL and testbench
====================================

MLP_JOB_SEQUENCER -- requirements
Module: mlp_job_sequencer

Interface
- REQ-001: Parameter ROWS, default 2: weight bytes pushed per column.
- REQ-002: Parameter MLP_DONE_STATE, default 4'd6: mlp_state value meaning the MLP finished.
- REQ-003: Parameter TIMEOUT, default 255: maximum WAIT cycles before abort.
- REQ-004: clk  in  1  single clock; all logic on posedge.
- REQ-005: rst_n  in  1  asynchronous, active-low reset.
- REQ-006: cmd_valid  in  1  job offered.
- REQ-007: cmd_ready  out  1  sequencer can accept a job.
- REQ-008: cmd_weights  in  16*ROWS  packed bytes; byte k at [8k+7:8k]; bytes 0..ROWS-1 go to col0, bytes ROWS..2*ROWS-1 go to col1.
- REQ-009: cmd_act  in  16  initial activation word.
- REQ-010: wf_push_col0, wf_push_col1  out  1 each  weight FIFO column push strobes.
- REQ-011: wf_data_in  out  8  weight byte.
- REQ-012: wf_reset  out  1  weight FIFO clear.
- REQ-013: init_act_valid  out  1  activation strobe.
- REQ-014: init_act_data  out  16  activation word.
- REQ-015: start_mlp  out  1  MLP start pulse.
- REQ-016: weights_ready  out  1  weights-loaded pulse.
- REQ-017: mlp_state  in  4  MLP state.
- REQ-018: mlp_acc0, mlp_acc1  in  32 signed each  MLP accumulators.
- REQ-019: res_valid  out  1  result available.
- REQ-020: res_ready  in  1  result consumer ready.
- REQ-021: res_acc0, res_acc1  out  32 signed each  captured accumulators.
- REQ-022: res_cycles  out  8  WAIT-cycle count, saturating at 255.
- REQ-023: res_timeout  out  1  job aborted by timeout.
- REQ-024: busy  out  1  high in every state except IDLE.

Function
- REQ-025: FSM states: IDLE, WRST, LOADW, WRDY, ACT, START, WAIT, RESULT.
- REQ-026: IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_weights and cmd_act into internal registers.
  - Next state WRST.
- REQ-027: WRST: wf_reset=1 for exactly one cycle, then LOADW.
- REQ-028: LOADW: lasts 2*ROWS cycles, one push per cycle.
  - Byte index i = 0..2*ROWS-1 from a counter.
  - wf_data_in = latched byte i.
  - wf_push_col0=1 for i<ROWS; wf_push_col1=1 for i>=ROWS.
  - Never both pushes high in the same cycle.
- REQ-029: WRDY: weights_ready=1 for one cycle, then ACT.
- REQ-030: ACT: init_act_valid=1 with init_act_data = latched act for one cycle, then START.
- REQ-031: START: start_mlp=1 for one cycle.
  - Wait counter cleared.
  - Next state WAIT.
- REQ-032: WAIT: counter increments each cycle.
  - Exit to RESULT on the first cycle mlp_state==MLP_DONE_STATE; capture mlp_acc0/1 that cycle with res_timeout=0.
  - Otherwise, exit to RESULT with res_timeout=1 and accumulators captured when counter reaches TIMEOUT.
  - Done wins if both conditions hold in the same cycle.
- REQ-033: res_cycles = WAIT cycles elapsed, including the exit cycle; saturates at 255.
- REQ-034: RESULT: res_valid=1 and all res_* held stable until res_ready.
  - On res_valid&&res_ready, return to IDLE.
- REQ-035: A new job is accepted no earlier than the cycle after the result handshake (no overlap).
- REQ-036: Strobe outputs (wf_push_*, wf_reset, init_act_valid, start_mlp, weights_ready) are registered; each is high only in its own state.
- REQ-037: Outputs unused in the current state hold their last value: wf_data_in, init_act_data, and res_* outside RESULT.
- REQ-038: Latency from job accept to start_mlp pulse = 2*ROWS+4 cycles.

Reset
- REQ-039: rst_n low asynchronously forces IDLE and drives all strobes, res_valid, res_timeout and busy to 0.
- REQ-040: Reset also clears res_acc0/1, res_cycles, wf_data_in, init_act_data and all counters to 0; cmd_ready=1 after release.
- REQ-041: Reset asserted mid-job (any state) abandons the job with no further strobes; no partial result is ever presented.

Verification
- REQ-042: Basic job.
  - Stimulus: ROWS=2, weights 0x04030201, act 0x0102; stub reaches DONE 10 cycles after start with acc0=7, acc1=-3.
  - Required: wf_reset, then col0 pushes 01,02 and col1 pushes 03,04; then weights_ready, init_act_valid(0x0102), start_mlp; res_valid with acc0=7, acc1=-3, res_cycles=10, res_timeout=0.
- REQ-043: Timeout.
  - Stimulus: TIMEOUT=20; stub never reaches DONE.
  - Required: res_valid after 20 WAIT cycles with res_timeout=1, res_cycles=20.
- REQ-044: Result backpressure.
  - Stimulus: hold res_ready=0 for 15 cycles; change mlp_acc inputs meanwhile.
  - Required: res_* stable throughout; cmd_ready=0 until the cycle after the handshake.
- REQ-045: Reset mid-job.
  - Stimulus: pulse rst_n low during LOADW.
  - Required: all strobes 0 immediately; busy=0; cmd_ready=1 after release; a following job runs correctly.
- REQ-046: Done/timeout collision.
  - Stimulus: DONE arrives exactly on cycle TIMEOUT.
  - Required: res_timeout=0.
- REQ-047: Back-to-back jobs.
  - Stimulus: cmd_valid held high across two jobs.
  - Required: second accept one cycle after the first result handshake; accept-to-start latency 8 cycles each.

Source files
------------

// File: rtl/mlp_job_sequencer.sv
// Job sequencer for a two-column MLP: clears and loads the weight FIFO, seeds the
// activation, starts the MLP, then waits for completion or timeout and holds the result.
module mlp_job_sequencer #(
    parameter int         ROWS           = 2,
    parameter logic [3:0] MLP_DONE_STATE = 4'd6,
    parameter int         TIMEOUT        = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [16*ROWS-1:0]     cmd_weights,
    input  logic [15:0]            cmd_act,
    output logic                   wf_push_col0,
    output logic                   wf_push_col1,
    output logic [7:0]             wf_data_in,
    output logic                   wf_reset,
    output logic                   init_act_valid,
    output logic [15:0]            init_act_data,
    output logic                   start_mlp,
    output logic                   weights_ready,
    input  logic [3:0]             mlp_state,
    input  logic signed [31:0]     mlp_acc0,
    input  logic signed [31:0]     mlp_acc1,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [31:0]     res_acc0,
    output logic signed [31:0]     res_acc1,
    output logic [7:0]             res_cycles,
    output logic                   res_timeout,
    output logic                   busy
);

    localparam int             NB        = 2 * ROWS;
    localparam int             IW        = $clog2(NB + 1);
    localparam logic [IW-1:0]  L_NB      = IW'(NB);
    localparam logic [IW-1:0]  L_ROWS    = IW'(ROWS);
    // The wait counter is 16 bits wide, so TIMEOUT must stay below 65536.
    localparam logic [15:0]    L_TIMEOUT = 16'(TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRST   = 3'd1;
    localparam logic [2:0] S_LOADW  = 3'd2;
    localparam logic [2:0] S_WRDY   = 3'd3;
    localparam logic [2:0] S_ACT    = 3'd4;
    localparam logic [2:0] S_START  = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;
    localparam logic [2:0] S_RESULT = 3'd7;

    function automatic logic [7:0] sat_cycles(input logic [15:0] n);
        return (n > 16'd255) ? 8'hFF : n[7:0];
    endfunction

    logic [2:0]             r_state;
    logic [IW-1:0]          r_idx;
    logic [15:0]            r_wcnt;
    logic [16*ROWS-1:0]     r_weights;
    logic [15:0]            r_act;
    logic                   r_wf_reset;
    logic                   r_push0;
    logic                   r_push1;
    logic [7:0]             r_wf_data;
    logic                   r_weights_ready;
    logic                   r_init_act_valid;
    logic [15:0]            r_init_act_data;
    logic                   r_start;
    logic                   r_res_valid;
    logic signed [31:0]     r_res_acc0;
    logic signed [31:0]     r_res_acc1;
    logic [7:0]             r_res_cycles;
    logic                   r_res_timeout;

    logic [15:0]            w_elapsed;
    logic                   w_done;
    logic [7:0]             w_byte;

    assign w_elapsed = r_wcnt + 16'd1;
    assign w_done    = (mlp_state == MLP_DONE_STATE);
    assign w_byte    = 8'(r_weights >> {r_idx, 3'b000});

    // Strobes are registered from the transition into their state, so each one is
    // high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_wcnt           <= '0;
            r_weights        <= '0;
            r_act            <= '0;
            r_wf_reset       <= 1'b0;
            r_push0          <= 1'b0;
            r_push1          <= 1'b0;
            r_wf_data        <= '0;
            r_weights_ready  <= 1'b0;
            r_init_act_valid <= 1'b0;
            r_init_act_data  <= '0;
            r_start          <= 1'b0;
            r_res_valid      <= 1'b0;
            r_res_acc0       <= '0;
            r_res_acc1       <= '0;
            r_res_cycles     <= '0;
            r_res_timeout    <= 1'b0;
        end else begin
            r_wf_reset       <= 1'b0;
            r_push0          <= 1'b0;
            r_push1          <= 1'b0;
            r_weights_ready  <= 1'b0;
            r_init_act_valid <= 1'b0;
            r_start          <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_weights  <= cmd_weights;
                        r_act      <= cmd_act;
                        r_idx      <= '0;
                        r_wf_reset <= 1'b1;
                        r_state    <= S_WRST;
                    end
                end
                // WRST already presents byte 0; LOADW then walks the rest and exits at NB.
                S_WRST, S_LOADW: begin
                    if (r_idx == L_NB) begin
                        r_weights_ready <= 1'b1;
                        r_state         <= S_WRDY;
                    end else begin
                        r_wf_data <= w_byte;
                        r_push0   <= (r_idx < L_ROWS);
                        r_push1   <= !(r_idx < L_ROWS);
                        r_idx     <= r_idx + IW'(1);
                        r_state   <= S_LOADW;
                    end
                end
                S_WRDY: begin
                    r_init_act_valid <= 1'b1;
                    r_init_act_data  <= r_act;
                    r_state          <= S_ACT;
                end
                S_ACT: begin
                    r_start <= 1'b1;
                    r_wcnt  <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wcnt <= w_elapsed;
                    if (w_done || (w_elapsed >= L_TIMEOUT)) begin
                        r_res_acc0    <= mlp_acc0;
                        r_res_acc1    <= mlp_acc1;
                        r_res_cycles  <= sat_cycles(w_elapsed);
                        r_res_timeout <= !w_done;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign wf_reset       = r_wf_reset;
    assign wf_push_col0   = r_push0;
    assign wf_push_col1   = r_push1;
    assign wf_data_in     = r_wf_data;
    assign weights_ready  = r_weights_ready;
    assign init_act_valid = r_init_act_valid;
    assign init_act_data  = r_init_act_data;
    assign start_mlp      = r_start;
    assign res_valid      = r_res_valid;
    assign res_acc0       = r_res_acc0;
    assign res_acc1       = r_res_acc1;
    assign res_cycles     = r_res_cycles;
    assign res_timeout    = r_res_timeout;

endmodule

// File: tb/tb_mlp_job_sequencer.sv
// Scoreboard bench for mlp_job_sequencer: stimulus queues expected strobe/result events,
// a negedge monitor pops and compares them; an MLP stub supplies mlp_state and accumulators.
module tb_mlp_job_sequencer;

    localparam int ROWS = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [16*ROWS-1:0] cmd_weights;
    logic [15:0]        cmd_act;
    logic               wf_push_col0, wf_push_col1, wf_reset;
    logic [7:0]         wf_data_in;
    logic               init_act_valid;
    logic [15:0]        init_act_data;
    logic               start_mlp, weights_ready;
    logic [3:0]         mlp_state;
    logic signed [31:0] mlp_acc0, mlp_acc1;
    logic               res_valid, res_ready;
    logic signed [31:0] res_acc0, res_acc1;
    logic [7:0]         res_cycles;
    logic               res_timeout;
    logic               busy;

    mlp_job_sequencer #(.ROWS(ROWS), .MLP_DONE_STATE(4'd6), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_weights(cmd_weights), .cmd_act(cmd_act),
        .wf_push_col0(wf_push_col0), .wf_push_col1(wf_push_col1),
        .wf_data_in(wf_data_in), .wf_reset(wf_reset),
        .init_act_valid(init_act_valid), .init_act_data(init_act_data),
        .start_mlp(start_mlp), .weights_ready(weights_ready),
        .mlp_state(mlp_state), .mlp_acc0(mlp_acc0), .mlp_acc1(mlp_acc1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_acc0(res_acc0), .res_acc1(res_acc1),
        .res_cycles(res_cycles), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MLP stub: s_cnt is 1 in the first cycle after start_mlp and counts up from there.
    int s_cnt;
    int done_after;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          s_cnt <= 0;
        else if (start_mlp)  s_cnt <= 1;
        else if (s_cnt != 0) s_cnt <= s_cnt + 1;
    end
    assign mlp_state = (done_after != 0 && s_cnt == done_after) ? 4'd6 : 4'd0;

    typedef struct {
        int          kind;
        logic [79:0] pay;
    } ev_t;
    ev_t q[$];

    int n_total = 0;
    int n_bad   = 0;
    int acc_cyc = 0;
    int hs_cyc  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_ev(input int k, input logic [79:0] p);
        ev_t e;
        e.kind = k;
        e.pay  = p;
        q.push_back(e);
    endtask

    task automatic exp_job(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [15:0] act,
                           input logic signed [31:0] a0, input logic signed [31:0] a1,
                           input logic [7:0] ncyc, input logic to);
        exp_ev(1, 80'(0));
        exp_ev(2, 80'(b0));
        exp_ev(2, 80'(b1));
        exp_ev(3, 80'(b2));
        exp_ev(3, 80'(b3));
        exp_ev(4, 80'(0));
        exp_ev(5, 80'(act));
        exp_ev(6, 80'(0));
        exp_ev(7, {7'd0, a0, a1, ncyc, to});
    endtask

    task automatic sb(input int k, input logic [79:0] p, input string name);
        ev_t e;
        if (q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: unexpected event kind %0d data %0h (cycle %0d)", name, k, p, cyc);
        end else begin
            e = q.pop_front();
            chk({name, "_order"}, 80'(k), 80'(e.kind));
            chk(name, p, e.pay);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            chk("push_exclusive", 80'(wf_push_col0 & wf_push_col1), 80'(0));
            if (wf_reset)       sb(1, 80'(0), "wf_reset");
            if (wf_push_col0)   sb(2, 80'(wf_data_in), "push_col0");
            if (wf_push_col1)   sb(3, 80'(wf_data_in), "push_col1");
            if (weights_ready)  sb(4, 80'(0), "weights_ready");
            if (init_act_valid) sb(5, 80'(init_act_data), "init_act");
            if (start_mlp) begin
                sb(6, 80'(0), "start_mlp");
                chk("accept_to_start", 80'(cyc - acc_cyc), 80'(8));
            end
            if (res_valid && res_ready) begin
                sb(7, {7'd0, res_acc0, res_acc1, res_cycles, res_timeout}, "result");
                chk("hs_cmd_ready", 80'(cmd_ready), 80'(0));
                hs_cyc = cyc;
            end
        end
    end

    task automatic wait_accept(output int c);
        bit ok = 1'b0;
        c = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                ok = 1'b1;
                c  = cyc;
            end
        end
        chk("accept_seen", 80'(ok), 80'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) ok = 1'b1;
        end
        chk("handshake_seen", 80'(ok), 80'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [31:0] w, input logic [15:0] a, input int da,
                           input logic signed [31:0] a0, input logic signed [31:0] a1);
        int c;
        cmd_weights = w;
        cmd_act     = a;
        done_after  = da;
        mlp_acc0    = a0;
        mlp_acc1    = a1;
        cmd_valid   = 1'b1;
        wait_accept(c);
        cmd_valid   = 1'b0;
        wait_hs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit ok;
        logic [72:0] snap;

        rst_n       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_weights = '0;
        cmd_act     = '0;
        res_ready   = 1'b1;
        done_after  = 0;
        mlp_acc0    = '0;
        mlp_acc1    = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 80'({wf_reset, wf_push_col0, wf_push_col1, weights_ready, init_act_valid,
                                start_mlp, res_valid, res_timeout, busy}), 80'(0));
        chk("rst_cmd_ready", 80'(cmd_ready), 80'(1));
        chk("rst_res", 80'({res_acc0, res_acc1, res_cycles}), 80'(0));
        chk("rst_data", 80'({wf_data_in, init_act_data}), 80'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic job
        exp_job(8'h01, 8'h02, 8'h03, 8'h04, 16'h0102, 32'sd7, -32'sd3, 8'd10, 1'b0);
        run_job(32'h04030201, 16'h0102, 10, 32'sd7, -32'sd3);

        // Timeout: the stub never reports done
        exp_job(8'hAA, 8'hBB, 8'hCC, 8'hDD, 16'hBEEF, 32'sd100, -32'sd100, 8'd20, 1'b1);
        run_job(32'hDDCCBBAA, 16'hBEEF, 0, 32'sd100, -32'sd100);

        // Done arrives on the same cycle the timeout would fire
        exp_job(8'h11, 8'h22, 8'h33, 8'h44, 16'h1234, -32'sd1, 32'sd5, 8'd20, 1'b0);
        run_job(32'h44332211, 16'h1234, 20, -32'sd1, 32'sd5);

        // Result backpressure
        exp_job(8'h0C, 8'h0D, 8'h0E, 8'h0F, 16'h5555, 32'sh12345678, -32'sd7, 8'd3, 1'b0);
        res_ready   = 1'b0;
        cmd_weights = 32'h0F0E0D0C;
        cmd_act     = 16'h5555;
        done_after  = 3;
        mlp_acc0    = 32'sh12345678;
        mlp_acc1    = -32'sd7;
        cmd_valid   = 1'b1;
        wait_accept(c);
        cmd_valid   = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
        end
        chk("bp_res_valid_seen", 80'(ok), 80'(1));
        snap = {res_acc0, res_acc1, res_cycles, res_timeout};
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            mlp_acc0 = mlp_acc0 + 32'sd1000 + 32'(i);
            mlp_acc1 = mlp_acc1 - 32'sd3;
            @(negedge clk);
            chk("bp_hold", 80'({res_valid, res_acc0, res_acc1, res_cycles, res_timeout}),
                80'({1'b1, snap}));
            chk("bp_cmd_ready", 80'(cmd_ready), 80'(0));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_hs();
        chk("post_hs_cmd_ready", 80'(cmd_ready), 80'(1));

        // Reset in the middle of LOADW
        exp_ev(1, 80'(0));
        exp_ev(2, 80'(8'h55));
        exp_ev(2, 80'(8'h66));
        cmd_weights = 32'h88776655;
        cmd_act     = 16'h7777;
        done_after  = 2;
        cmd_valid   = 1'b1;
        wait_accept(c);
        cmd_valid   = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (wf_push_col0 && wf_data_in == 8'h66) ok = 1'b1;
        end
        chk("rm_second_push_seen", 80'(ok), 80'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_strobes", 80'({wf_reset, wf_push_col0, wf_push_col1, weights_ready, init_act_valid,
                               start_mlp, res_valid, res_timeout, busy}), 80'(0));
        chk("rm_cmd_ready", 80'(cmd_ready), 80'(1));
        chk("rm_pending", 80'(q.size()), 80'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rm_idle_after", 80'({cmd_ready, busy, res_valid}), 80'(3'b100));

        // Job after reset, done on the very first WAIT cycle
        exp_job(8'hA1, 8'hA2, 8'hA3, 8'hA4, 16'h0A0B, 32'sd42, 32'sd43, 8'd1, 1'b0);
        run_job(32'hA4A3A2A1, 16'h0A0B, 1, 32'sd42, 32'sd43);

        // Back-to-back jobs with cmd_valid held high
        exp_job(8'h11, 8'h12, 8'h13, 8'h14, 16'h0001, 32'sd1, 32'sd2, 8'd5, 1'b0);
        exp_job(8'h21, 8'h22, 8'h23, 8'h24, 16'h0002, 32'sd3, 32'sd4, 8'd6, 1'b0);
        cmd_weights = 32'h14131211;
        cmd_act     = 16'h0001;
        done_after  = 5;
        mlp_acc0    = 32'sd1;
        mlp_acc1    = 32'sd2;
        cmd_valid   = 1'b1;
        wait_accept(c);
        cmd_weights = 32'h24232221;
        cmd_act     = 16'h0002;
        wait_hs();
        done_after  = 6;
        mlp_acc0    = 32'sd3;
        mlp_acc1    = 32'sd4;
        wait_accept(c);
        chk("b2b_accept_gap", 80'(c - hs_cyc), 80'(1));
        cmd_valid   = 1'b0;
        wait_hs();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 80'(q.size()), 80'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
